// File: rtl/laser_controller_pkg.sv
// Shared widths, laser FSM state encoding and the spawn-row helper for the laser controller.
package laser_controller_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_READY = 3'd1,
        S_FLY   = 3'd2,
        S_HIT   = 3'd3,
        S_END   = 3'd4
    } laser_state_t;

    // Row at which a new laser appears: offset rows above the rocket, never above the retire row.
    function automatic logic [Y_W-1:0] spawn_row(input logic [Y_W-1:0] rocket_row,
                                                 input int top_y,
                                                 input int offset);
        int r;
        r = int'(rocket_row);
        if (r < top_y + offset)
            return Y_W'(top_y);
        return Y_W'(r - offset);
    endfunction

endpackage

// File: rtl/laser_step_timer.sv
// Free-running step counter for the laser: counts 0..STEP_CYCLES-1 while enabled and flags
// the last count so the laser moves one row as the counter wraps.
module laser_step_timer #(
    parameter int STEP_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    // Count while enabled, wrap on the step tick, restart from zero on every spawn.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= tick ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/laser_controller.sv
// Single player laser: spawns at the rocket on a fire press, climbs one row per step tick and
// retires at the top row or on a collision hit. All outputs are registered.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_OFF   | game not running, laser logic idle
//  S_READY | game running, waiting for a fire press
//  S_FLY   | laser in flight, moving up one row per step tick
//  S_HIT   | retired by destroy_laser, laser_destroyed pulses next clock
//  S_END   | reached the top row, laser_move_done pulses next clock
module laser_controller
    import laser_controller_pkg::*;
#(
    parameter int STEP_CYCLES  = 833333,
    parameter int TOP_Y        = 0,
    parameter int SPAWN_OFFSET = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           fire,
    input  logic [X_W-1:0] rocketx,
    input  logic [Y_W-1:0] rockety,
    input  logic           destroy_laser,
    output logic [X_W-1:0] laser_x,
    output logic [Y_W-1:0] laser_y,
    output logic           laser_active,
    output logic           laser_move_done,
    output logic           laser_destroyed
);

    localparam logic [Y_W-1:0] TOP_ROW = Y_W'(TOP_Y);

    laser_state_t   state, state_n;
    logic           fire_q;
    logic           fire_edge;
    logic           step_tick;
    logic           timer_clear;
    logic [X_W-1:0] x_n;
    logic [Y_W-1:0] y_n;
    logic           active_n;
    logic           done_n;
    logic           destroyed_n;

    assign fire_edge = fire & ~fire_q;

    laser_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .enable(state == S_FLY),
        .tick  (step_tick)
    );

    // Next state and next output values; laser_active drops on the edge that leaves S_FLY,
    // while the retirement pulses come from the one-cycle S_HIT/S_END states.
    always_comb begin
        state_n     = state;
        x_n         = laser_x;
        y_n         = laser_y;
        active_n    = laser_active;
        done_n      = 1'b0;
        destroyed_n = 1'b0;
        timer_clear = 1'b0;
        case (state)
            S_OFF: begin
                if (start)
                    state_n = S_READY;
            end
            S_READY: begin
                if (!start) begin
                    state_n = S_OFF;
                end else if (fire_edge) begin
                    state_n     = S_FLY;
                    x_n         = rocketx;
                    y_n         = spawn_row(rockety, TOP_Y, SPAWN_OFFSET);
                    active_n    = 1'b1;
                    timer_clear = 1'b1;
                end
            end
            S_FLY: begin
                if (!start) begin
                    state_n  = S_OFF;
                    active_n = 1'b0;
                end else if (destroy_laser) begin
                    state_n  = S_HIT;
                    active_n = 1'b0;
                end else if (step_tick) begin
                    if (laser_y == TOP_ROW) begin
                        state_n  = S_END;
                        active_n = 1'b0;
                    end else begin
                        y_n = laser_y - Y_W'(1);
                    end
                end
            end
            S_HIT: begin
                destroyed_n = 1'b1;
                state_n     = S_READY;
            end
            S_END: begin
                done_n  = 1'b1;
                state_n = S_READY;
            end
            default: begin
                state_n  = S_OFF;
                active_n = 1'b0;
            end
        endcase
    end

    // State, fire history and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= S_OFF;
            fire_q          <= 1'b0;
            laser_x         <= '0;
            laser_y         <= '0;
            laser_active    <= 1'b0;
            laser_move_done <= 1'b0;
            laser_destroyed <= 1'b0;
        end else begin
            state           <= state_n;
            fire_q          <= fire;
            laser_x         <= x_n;
            laser_y         <= y_n;
            laser_active    <= active_n;
            laser_move_done <= done_n;
            laser_destroyed <= destroyed_n;
        end
    end

endmodule

// File: tb/tb_laser_controller.sv
// Scoreboard bench for laser_controller: each flight is planned from the game rules (spawn row,
// rows climbed per STEP cycles, hit or top-row retirement) and the expected spawn/retire events
// are queued; a negedge monitor pops and compares whenever the DUT shows such an event.
module tb_laser_controller;

    localparam int STEP     = 4;
    localparam int EV_SPAWN = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_HIT   = 2;

    typedef struct {
        int kind;
        int cyc;
        int x;
        int y;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       fire;
    logic [7:0] rocketx;
    logic [6:0] rockety;
    logic       destroy_laser;
    logic [7:0] laser_x;
    logic [6:0] laser_y;
    logic       laser_active;
    logic       laser_move_done;
    logic       laser_destroyed;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  q[$];
    logic prev_active = 1'b0;

    laser_controller #(
        .STEP_CYCLES (STEP),
        .TOP_Y       (0),
        .SPAWN_OFFSET(1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .fire           (fire),
        .rocketx        (rocketx),
        .rockety        (rockety),
        .destroy_laser  (destroy_laser),
        .laser_x        (laser_x),
        .laser_y        (laser_y),
        .laser_active   (laser_active),
        .laser_move_done(laser_move_done),
        .laser_destroyed(laser_destroyed)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cyc=%0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, want no event", kind, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_SPAWN && (e.x != int'(laser_x) || e.y != int'(laser_y)))) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d x=%0d y=%0d want kind=%0d cyc=%0d x=%0d y=%0d",
                         kind, cyc, laser_x, laser_y, e.kind, e.cyc, e.x, e.y);
            end
        end
    endtask

    // Monitor: any spawn (laser_active rising) or retirement pulse is matched against the queue.
    always @(negedge clock) begin
        if (reset) begin
            prev_active = 1'b0;
        end else begin
            if (laser_active && !prev_active) check_event(EV_SPAWN);
            if (laser_move_done)              check_event(EV_DONE);
            if (laser_destroyed)              check_event(EV_HIT);
            prev_active = laser_active;
        end
    end

    // One complete flight. mode 0: climbs to the top; 1: hit at a random point; 2: hit on the
    // same clock as the final step. hold = cycles fire stays high; refire = second press in flight.
    task automatic episode(input int x, input int ry, input int mode, input int hold, input bit refire);
        int s, y0, end_edge, dn, stop, act_end;
        y0 = (ry < 1) ? 0 : ry - 1;
        @(negedge clock);
        rocketx = 8'(x);
        rockety = 7'(ry);
        fire    = 1'b1;
        s        = cyc + 1;
        end_edge = s + STEP * (y0 + 1);
        dn       = -10;
        q.push_back('{EV_SPAWN, s, x, y0});
        if (mode == 0) begin
            act_end = end_edge;
            stop    = end_edge + 1;
            q.push_back('{EV_DONE, stop, x, 0});
        end else begin
            dn      = (mode == 2) ? end_edge - 1 : int'($urandom_range(end_edge - 1, s));
            act_end = dn + 1;
            stop    = dn + 2;
            q.push_back('{EV_HIT, stop, x, 0});
        end
        while (cyc < stop + 2) begin
            @(negedge clock);
            destroy_laser = (cyc == dn);
            fire          = ((cyc - s + 1) < hold) || (refire && cyc == s + 2);
            rocketx       = 8'($urandom);
            rockety       = 7'($urandom);
            chk("active", int'(laser_active), int'(cyc >= s && cyc < act_end));
            if (cyc >= s && cyc < act_end) begin
                chk("laser_x", int'(laser_x), x);
                chk("laser_y", int'(laser_y), y0 - (cyc - s) / STEP);
            end
        end
        destroy_laser = 1'b0;
        fire          = 1'b0;
        chk("x_held", int'(laser_x), x);
        if (mode == 0)
            chk("y_held_top", int'(laser_y), 0);
        else
            chk("y_held_hit", int'(laser_y), y0 - (dn - s) / STEP);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        reset         = 1'b1;
        start         = 1'b0;
        fire          = 1'b0;
        destroy_laser = 1'b0;
        rocketx       = '0;
        rockety       = '0;
        #3;
        chk("rst_x", int'(laser_x), 0);
        chk("rst_y", int'(laser_y), 0);
        chk("rst_active", int'(laser_active), 0);
        chk("rst_done", int'(laser_move_done), 0);
        chk("rst_destroyed", int'(laser_destroyed), 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clock);

        episode(80, 110, 0, 2, 1'b0);
        episode(37, 3, 0, 1, 1'b0);
        episode(200, 5, 1, 1, 1'b0);
        episode(12, 2, 2, 1, 1'b0);
        episode(99, 4, 0, 1000, 1'b0);
        episode(150, 4, 0, 2, 1'b1);
        episode(7, 0, 0, 1, 1'b0);
        episode(8, 1, 2, 1, 1'b0);

        // destroy_laser while waiting for fire must not produce a pulse
        @(negedge clock);
        destroy_laser = 1'b1;
        @(negedge clock);
        destroy_laser = 1'b0;
        repeat (4) @(negedge clock);
        chk("ready_no_pulse", int'(laser_destroyed | laser_move_done), 0);

        // start dropped mid-flight: laser goes dark silently, fire ignored while stopped
        @(negedge clock);
        rocketx = 8'd44;
        rockety = 7'd20;
        fire    = 1'b1;
        s       = cyc + 1;
        q.push_back('{EV_SPAWN, s, 44, 19});
        @(negedge clock);
        fire = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("stop_active", int'(laser_active), 0);
        chk("stop_y_held", int'(laser_y), 19);
        @(negedge clock);
        fire = 1'b1;
        @(negedge clock);
        fire = 1'b0;
        repeat (3) @(negedge clock);
        chk("off_no_spawn", int'(laser_active), 0);
        start = 1'b1;
        @(negedge clock);

        // asynchronous reset mid-flight, applied between clock edges
        @(negedge clock);
        rocketx = 8'd66;
        rockety = 7'd50;
        fire    = 1'b1;
        s       = cyc + 1;
        q.push_back('{EV_SPAWN, s, 66, 49});
        @(negedge clock);
        fire = 1'b0;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_x", int'(laser_x), 0);
        chk("arst_y", int'(laser_y), 0);
        chk("arst_active", int'(laser_active), 0);
        chk("arst_done", int'(laser_move_done), 0);
        chk("arst_destroyed", int'(laser_destroyed), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int mode, hold;
            bit refire;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                destroy_laser = 1'b1;
                @(negedge clock);
                destroy_laser = 1'b0;
            end
            mode   = int'($urandom_range(0, 2));
            hold   = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, 2));
            refire = (mode == 0 && hold <= 2 && $urandom_range(0, 1) == 1);
            episode(int'($urandom_range(0, 255)), int'($urandom_range(0, 9)), mode, hold, refire);
        end

        repeat (4) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
